// File: rtl/gpu_instruction_dispatcher.sv
// gpu_instruction_dispatcher
// Fetches drawing commands from an instruction FIFO and decodes them. Each command
// is issued in order to the outline engine (A) or the fill engine (B). The block
// tracks which engines are busy, handles SYNC barriers and flags illegal opcodes.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   fifo_empty_i               FIFO empty flag
//   opcode_i..oct_i            FIFO head word (combinational)
//   pop_instruction_o          one-cycle pop strobe back to the FIFO
//   halt_i                     host pause, blocks new fetches only
//   eng_{a,b}_start_o          one-cycle engine start
//   eng_{a,b}_done_i           one-cycle engine completion
//   eng_{a,b}_abort_o          one-cycle watchdog abort
//   opcode_o..oct_o            registered command bus, held until next capture
//   busy_o                     instruction in flight or any engine busy
//   err_o                      sticky errors: [0] illegal opcode, [1] timeout
//   err_clr_i                  clears err_o
//   irq_o                      one-cycle pulse on any new error
//
// Optional feature: define GPU_DISPATCH_TIMEOUT_EN to add per-engine watchdogs
// that abort an engine after TIMEOUT_CYCLES busy cycles.

`ifndef WIDTH_BITS
`define WIDTH_BITS 10
`endif
`ifndef HEIGHT_BITS
`define HEIGHT_BITS 9
`endif
`ifndef CHANNEL_BITS
`define CHANNEL_BITS 8
`endif

module gpu_instruction_dispatcher #(
    parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      fifo_empty_i,
    input  logic [3:0]                opcode_i,
    input  logic [`WIDTH_BITS-1:0]    x1_i,
    input  logic [`HEIGHT_BITS-1:0]   y1_i,
    input  logic [`WIDTH_BITS-1:0]    x2_i,
    input  logic [`HEIGHT_BITS-1:0]   y2_i,
    input  logic [`WIDTH_BITS-1:0]    rad_i,
    input  logic [`CHANNEL_BITS-1:0]  r_i,
    input  logic [`CHANNEL_BITS-1:0]  g_i,
    input  logic [`CHANNEL_BITS-1:0]  b_i,
    input  logic [2:0]                oct_i,
    output logic                      pop_instruction_o,
    input  logic                      halt_i,
    output logic                      eng_a_start_o,
    output logic                      eng_b_start_o,
    input  logic                      eng_a_done_i,
    input  logic                      eng_b_done_i,
    output logic                      eng_a_abort_o,
    output logic                      eng_b_abort_o,
    output logic [3:0]                opcode_o,
    output logic [`WIDTH_BITS-1:0]    x1_o,
    output logic [`HEIGHT_BITS-1:0]   y1_o,
    output logic [`WIDTH_BITS-1:0]    x2_o,
    output logic [`HEIGHT_BITS-1:0]   y2_o,
    output logic [`WIDTH_BITS-1:0]    rad_o,
    output logic [`CHANNEL_BITS-1:0]  r_o,
    output logic [`CHANNEL_BITS-1:0]  g_o,
    output logic [`CHANNEL_BITS-1:0]  b_o,
    output logic [2:0]                oct_o,
    output logic                      busy_o,
    output logic [1:0]                err_o,
    input  logic                      err_clr_i,
    output logic                      irq_o
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_SYNC,
        ST_ERROR
    } state_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_SYNC = 4'd7;

    // Command word kept as one packed register so capture/hold is a single mux
    localparam int CMD_W = 4 + 3 * `WIDTH_BITS + 2 * `HEIGHT_BITS + 3 * `CHANNEL_BITS + 3;

    state_t             state_q, state_d;
    logic               busy_a_q, busy_a_d, busy_b_q, busy_b_d;
    logic [1:0]         err_q, err_d;
    logic [CMD_W-1:0]   cmd_q, cmd_d;
    logic               pop, start_a, start_b, illegal;
    logic               abort_a, abort_b;
    logic               target_a;

    // Opcodes 1,2,4,5 draw outlines on engine A; 3 and 6 are fills on engine B
    assign target_a = (cmd_q[CMD_W-1 -: 4] == 4'd1) || (cmd_q[CMD_W-1 -: 4] == 4'd2) ||
                      (cmd_q[CMD_W-1 -: 4] == 4'd4) || (cmd_q[CMD_W-1 -: 4] == 4'd5);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        start_a = 1'b0;
        start_b = 1'b0;
        illegal = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty_i && !halt_i) begin
                    pop     = 1'b1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (cmd_q[CMD_W-1 -: 4] == OP_NOP)       state_d = ST_IDLE;
                else if (cmd_q[CMD_W-1 -: 4] == OP_SYNC) state_d = ST_SYNC;
                else if (cmd_q[CMD_W-1])                 state_d = ST_ERROR;
                else                                     state_d = ST_ISSUE;
            end
            ST_ISSUE: begin
                // Head of line blocks: nothing else is fetched until this issues
                if (target_a) begin
                    if (!busy_a_q) begin
                        start_a = 1'b1;
                        state_d = ST_IDLE;
                    end
                end else if (!busy_b_q) begin
                    start_b = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_SYNC: begin
                if (!busy_a_q && !busy_b_q) state_d = ST_IDLE;
            end
            ST_ERROR: begin
                illegal = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // Strobes must stay low while reset is held, even before state settles
        if (rst) begin
            pop     = 1'b0;
            start_a = 1'b0;
            start_b = 1'b0;
            illegal = 1'b0;
        end
    end

    // Busy tracking, error latching and command capture
    always_comb begin
        cmd_d = cmd_q;
        if (pop) begin
            cmd_d = {opcode_i, x1_i, y1_i, x2_i, y2_i, rad_i, r_i, g_i, b_i, oct_i};
        end
        busy_a_d = busy_a_q;
        if (start_a)                          busy_a_d = 1'b1;
        else if (eng_a_done_i || abort_a)     busy_a_d = 1'b0;
        busy_b_d = busy_b_q;
        if (start_b)                          busy_b_d = 1'b1;
        else if (eng_b_done_i || abort_b)     busy_b_d = 1'b0;
        // Clear first so an error in the same cycle still lands
        err_d    = err_clr_i ? 2'b00 : err_q;
        err_d[0] = err_d[0] | illegal;
        err_d[1] = err_d[1] | abort_a | abort_b;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            busy_a_q <= 1'b0;
            busy_b_q <= 1'b0;
            err_q    <= 2'b00;
            cmd_q    <= '0;
        end else begin
            state_q  <= state_d;
            busy_a_q <= busy_a_d;
            busy_b_q <= busy_b_d;
            err_q    <= err_d;
            cmd_q    <= cmd_d;
        end
    end

`ifdef GPU_DISPATCH_TIMEOUT_EN
    logic [15:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Counter value is busy cycles minus one, so abort fires exactly
    // TIMEOUT_CYCLES cycles after the start pulse; a done that cycle wins
    assign abort_a = !rst && busy_a_q && !eng_a_done_i && ((cnt_a_q + 16'd1) == TIMEOUT_CYCLES);
    assign abort_b = !rst && busy_b_q && !eng_b_done_i && ((cnt_b_q + 16'd1) == TIMEOUT_CYCLES);

    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (start_a)       cnt_a_d = 16'd0;
        else if (busy_a_q) cnt_a_d = cnt_a_q + 16'd1;
        if (start_b)       cnt_b_d = 16'd0;
        else if (busy_b_q) cnt_b_d = cnt_b_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_a_q <= 16'd0;
            cnt_b_q <= 16'd0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end
`else
    logic [15:0] unused_timeout;
    assign unused_timeout = TIMEOUT_CYCLES;
    assign abort_a = 1'b0;
    assign abort_b = 1'b0;
`endif

    assign pop_instruction_o = pop;
    assign eng_a_start_o     = start_a;
    assign eng_b_start_o     = start_b;
    assign eng_a_abort_o     = abort_a;
    assign eng_b_abort_o     = abort_b;
    assign irq_o             = illegal | abort_a | abort_b;
    assign busy_o            = !rst && ((state_q != ST_IDLE) || busy_a_q || busy_b_q);
    assign err_o             = err_q;
    assign {opcode_o, x1_o, y1_o, x2_o, y2_o, rad_o, r_o, g_o, b_o, oct_o} = cmd_q;

endmodule
